// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial sequencer around a 1-bit ALU slice: latches operands, then walks
// the slice LSB-first for WIDTH cycles, rippling Cout back into Cin.
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_ainv,
  output logic             alu_binv,
  output logic             alu_cin,
  output logic [1:0]       alu_op,
  input  logic             alu_res,
  input  logic             alu_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef enum logic [2:0] {
    F_AND  = 3'd0,
    F_OR   = 3'd1,
    F_ADD  = 3'd2,
    F_SUB  = 3'd3,
    F_NOR  = 3'd4,
    F_NAND = 3'd5
  } func_t;

  typedef struct packed {
    logic       ainv;
    logic       binv;
    logic [1:0] op;
    logic       arith;
  } ctl_t;

  // Slice control for each function; reserved codes select op 3, which the slice answers with 0.
  function automatic ctl_t decode(input logic [2:0] f);
    ctl_t c;
    case (f)
      F_AND:   c = '{ainv: 1'b0, binv: 1'b0, op: 2'd0, arith: 1'b0};
      F_OR:    c = '{ainv: 1'b0, binv: 1'b0, op: 2'd1, arith: 1'b0};
      F_ADD:   c = '{ainv: 1'b0, binv: 1'b0, op: 2'd2, arith: 1'b1};
      F_SUB:   c = '{ainv: 1'b0, binv: 1'b1, op: 2'd2, arith: 1'b1};
      F_NOR:   c = '{ainv: 1'b1, binv: 1'b1, op: 2'd0, arith: 1'b0};
      F_NAND:  c = '{ainv: 1'b1, binv: 1'b1, op: 2'd1, arith: 1'b0};
      default: c = '{ainv: 1'b0, binv: 1'b0, op: 2'd3, arith: 1'b0};
    endcase
    return c;
  endfunction

  state_t          r_state;
  logic [IDXW-1:0] r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  ctl_t            r_ctl;
  logic            r_carry;
  logic [WIDTH-1:0] r_result;
  logic            r_carry_out;
  logic            r_overflow;
  logic            r_zero;
  logic            r_busy;
  logic            r_done;

  logic             w_run;
  logic [WIDTH-1:0] w_next_result;

  assign w_run = (r_state == S_RUN);

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_result        = r_result;
    w_next_result[r_idx] = alu_res;
  end

  assign alu_a    = w_run & r_a[r_idx];
  assign alu_b    = w_run & r_b[r_idx];
  assign alu_ainv = w_run & r_ctl.ainv;
  assign alu_binv = w_run & r_ctl.binv;
  assign alu_cin  = w_run & r_carry;
  assign alu_op   = w_run ? r_ctl.op : 2'd0;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: reset is synchronous; operands are cleared too so nothing stale survives an abort.
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_ctl       <= '0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_a     <= op_a;
            r_b     <= op_b;
            r_ctl   <= decode(func);
            r_idx   <= '0;
            r_carry <= (func == F_SUB);
          end
        end
        S_RUN: begin
          r_result <= w_next_result;
          r_zero   <= (w_next_result == '0);
          r_carry  <= alu_cout;
          if (r_idx == IDX_LAST) begin
            // Overflow is carry into the MSB xor carry out of it.
            r_carry_out <= r_ctl.arith & alu_cout;
            r_overflow  <= r_ctl.arith & (r_carry ^ alu_cout);
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_ONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Self-checking bench: a 1-bit slice model closes the loop around the DUT and an
// arithmetic reference model predicts every observable output each cycle.
module tb_bit_serial_alu_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   func;
  logic [W-1:0] op_a, op_b;
  logic         alu_a, alu_b, alu_ainv, alu_binv, alu_cin;
  logic [1:0]   alu_op;
  logic         alu_res, alu_cout;
  logic         busy, done, carry_out, overflow, zero;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  bit_serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .func(func), .op_a(op_a), .op_b(op_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ainv(alu_ainv), .alu_binv(alu_binv),
    .alu_cin(alu_cin), .alu_op(alu_op), .alu_res(alu_res), .alu_cout(alu_cout),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  // 1-bit ALU slice
  logic s_a, s_b;
  always_comb begin
    s_a = alu_a ^ alu_ainv;
    s_b = alu_b ^ alu_binv;
    alu_res  = 1'b0;
    alu_cout = 1'b0;
    case (alu_op)
      2'd0: alu_res = s_a & s_b;
      2'd1: alu_res = s_a | s_b;
      2'd2: alu_res = s_a ^ s_b ^ alu_cin;
      default: alu_res = 1'b0;
    endcase
    if (alu_op != 2'd3) alu_cout = (s_a & s_b) | (s_a & alu_cin) | (s_b & alu_cin);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: whole-word arithmetic.
  function automatic void ref_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic c, output logic v);
    logic [W:0] s;
    c = 1'b0; v = 1'b0; r = '0;
    case (f)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0]; c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd3: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[W-1:0]; c = (a >= b);
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd4: r = ~(a | b);
      3'd5: r = ~(a & b);
      default: r = '0;
    endcase
  endfunction

  function automatic logic [3:0] exp_ctl(input logic [2:0] f);
    case (f)
      3'd0: return 4'b0000;
      3'd1: return 4'b0001;
      3'd2: return 4'b0010;
      3'd3: return 4'b0110;
      3'd4: return 4'b1100;
      3'd5: return 4'b1101;
      default: return 4'b0011;
    endcase
  endfunction

  // Carry entering bit i: carry out of the low i bits of the sum.
  function automatic logic exp_cin(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input int i);
    int mask, sa, sb;
    mask = (1 << i) - 1;
    sa = int'(a) & mask;
    sb = ((f == 3'd3) ? int'(~b) : int'(b)) & mask;
    return 1'((sa + sb + ((f == 3'd3) ? 1 : 0)) >> i);
  endfunction

  // Model timeline: phase 0 idle, 1..W running bit phase-1, W+1 done.
  int           phase   = 0;
  bit           m_valid = 0;
  logic [W-1:0] m_a, m_b, p_res, h_res;
  logic [2:0]   m_f;
  logic         p_c, p_v, h_c, h_v;

  always @(posedge clk) begin
    if (rst) begin
      phase = 0; m_valid = 1;
      h_res = '0; h_c = 1'b0; h_v = 1'b0;
    end else if (phase == 0) begin
      if (start) begin
        phase = 1; m_a = op_a; m_b = op_b; m_f = func;
        ref_op(func, op_a, op_b, p_res, p_c, p_v);
      end
    end else if (phase == W) begin
      phase = W + 1; h_res = p_res; h_c = p_c; h_v = p_v;
    end else if (phase == W + 1) begin
      phase = 0;
    end else begin
      phase = phase + 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      if (done) done_cnt++;
      check("busy", busy, (phase >= 1 && phase <= W));
      check("done", done, (phase == W + 1));
      if (phase == 0 || phase == W + 1) begin
        check("result", result, h_res);
        check("carry_out", carry_out, h_c);
        check("overflow", overflow, h_v);
        check("zero", zero, (h_res == '0));
        check("alu_idle", {alu_a, alu_b, alu_ainv, alu_binv, alu_cin, alu_op}, 0);
      end else begin
        check("alu_a", alu_a, m_a[phase-1]);
        check("alu_b", alu_b, m_b[phase-1]);
        check("alu_ctl", {alu_ainv, alu_binv, alu_op}, exp_ctl(m_f));
        if (m_f == 3'd2 || m_f == 3'd3) check("alu_cin", alu_cin, exp_cin(m_f, m_a, m_b, phase - 1));
      end
    end
  end

  task automatic run_op(input string tag, input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ec, input logic ev, input logic ez);
    int lat;
    bit got;
    @(negedge clk);
    start = 1'b1; func = f; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; func = 3'($urandom); op_a = W'($urandom); op_b = W'($urandom);
    if (f == 3'd3) begin
      check({tag, "_first_cin"}, alu_cin, 1'b1);
      check({tag, "_first_binv"}, alu_binv, 1'b1);
    end
    lat = 0; got = 0;
    while (lat < 20 && !got) begin
      @(posedge clk); #1;
      lat++;
      if (done) got = 1;
    end
    check({tag, "_done_seen"}, got, 1'b1);
    check({tag, "_done_cycle"}, lat + 1, W + 1);
    check({tag, "_result"}, result, er);
    check({tag, "_carry"}, carry_out, ec);
    check({tag, "_ovf"}, overflow, ev);
    check({tag, "_zero"}, zero, ez);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  int dc0;

  initial begin
    rst = 1'b1; start = 1'b0; func = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1'b1);
    check("rst_flags", {carry_out, overflow}, 0);
    @(negedge clk); rst = 1'b0;

    run_op("add7f", 3'd2, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("sub55", 3'd3, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("and",   3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
    run_op("or",    3'd1, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_op("nor",   3'd4, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b1);
    run_op("nand",  3'd5, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    run_op("addff", 3'd2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("sub80", 3'd3, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
    run_op("rsvd",  3'd6, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b0, 1'b1);

    // Start pulsed mid-RUN is ignored.
    dc0 = done_cnt;
    @(negedge clk); start = 1'b1; func = 3'd2; op_a = 8'h12; op_b = 8'h34;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1; func = 3'd0; op_a = 8'hFF; op_b = 8'hFF;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("midrun_done", done, 1'b1);
    check("midrun_result", result, 8'h46);
    repeat (12) @(posedge clk);
    #1 check("midrun_one_done", done_cnt - dc0, 1);

    // Reset at RUN cycle 4 aborts silently.
    dc0 = done_cnt;
    @(negedge clk); start = 1'b1; func = 3'd2; op_a = 8'h11; op_b = 8'h22;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_result", result, 0);
    check("abort_zero", zero, 1'b1);
    repeat (12) @(posedge clk);
    #1 check("abort_no_done", done_cnt - dc0, 0);
    run_op("post_abort", 3'd2, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0);

    // rst and start together: rst wins.
    @(negedge clk); rst = 1'b1; start = 1'b1; func = 3'd2; op_a = 8'h01; op_b = 8'h01;
    @(posedge clk); #1;
    check("rst_start_busy", busy, 1'b0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    // start held high restarts one cycle after each DONE.
    dc0 = done_cnt;
    @(negedge clk); start = 1'b1; func = 3'd3; op_a = 8'h40; op_b = 8'h13;
    repeat (30) @(posedge clk);
    @(negedge clk); start = 1'b0;
    #1 check("held_start_dones", done_cnt - dc0, 3);
    repeat (15) @(posedge clk);

    // Random traffic: sporadic starts, occasional resets, operands churning.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 79) == 0);
      func  = 3'($urandom_range(0, 7));
      op_a  = W'($urandom);
      op_b  = W'($urandom);
    end
    @(negedge clk); start = 1'b0; rst = 1'b0;
    repeat (W + 4) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
